// File: rtl/decoupled_serializer.sv
// decoupled_serializer: splits IN_WIDTH-bit words into OUT_WIDTH-bit slices, LSB slice first.
// Optional out_last port enabled by defining SERIALIZER_LAST_EN.
`default_nettype none

module decoupled_serializer #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data
`ifdef SERIALIZER_LAST_EN
   ,
   output logic                 out_last
`endif
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int CNT_W = (RATIO < 2) ? 1 : $clog2(RATIO);
   localparam int OFS_W = $clog2(IN_WIDTH);

   generate
      if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
         $error("decoupled_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
      end
   endgenerate

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [IN_WIDTH-1:0] holding, holding_nxt;
   logic                last_slice;
   logic                in_hs;
   logic                out_hs;
   logic [OFS_W-1:0]    ofs;

   assign last_slice = (cnt == CNT_W'(RATIO - 1));
   assign out_valid  = (state == BUSY);
   assign in_ready   = (state == IDLE) | (out_ready & last_slice);
   assign in_hs      = in_valid & in_ready;
   assign out_hs     = out_valid & out_ready;

   // Slice select depends only on registered state, never on in_data.
   assign ofs      = OFS_W'(cnt) * OFS_W'(OUT_WIDTH);
   assign out_data = holding[ofs +: OUT_WIDTH];

`ifdef SERIALIZER_LAST_EN
   assign out_last = out_valid & last_slice;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= IDLE;
         cnt     <= '0;
         holding <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         holding <= holding_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      holding_nxt = holding;
      case (state)
         IDLE: begin
            if (in_hs) begin
               holding_nxt = in_data;
               cnt_nxt     = '0;
               state_nxt   = BUSY;
            end
         end
         BUSY: begin
            if (out_hs) begin
               if (!last_slice) begin
                  cnt_nxt = cnt + 1'b1;
               end else if (in_hs) begin
                  // Reload on the final slice keeps the stream bubble-free.
                  holding_nxt = in_data;
                  cnt_nxt     = '0;
               end else begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_decoupled_serializer.sv
// tb_decoupled_serializer: directed and randomized checks against a slice-queue reference model.
`default_nettype none

module tb_decoupled_serializer;

   localparam int IW    = 64;
   localparam int OW    = 8;
   localparam int RATIO = IW / OW;

   logic          clk = 1'b0;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
`ifdef SERIALIZER_LAST_EN
   logic          out_last;
`endif

   decoupled_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef SERIALIZER_LAST_EN
      ,
      .out_last  (out_last)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference: the queue holds every slice still owed downstream, in order.
   logic [OW-1:0] q[$];
   bit            armed   = 1'b0;
   bit            zero_ok = 1'b0;
   int            n_acc   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic iv, input logic [IW-1:0] id, input logic ordy);
      logic exp_valid, exp_ready, ihs, ohs;
      @(negedge clk);
      rstn      = r;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
      exp_valid = (q.size() != 0);
      exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
      if (armed) begin
         chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
         chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
         if (exp_valid)
            chk("out_data", {56'd0, out_data}, {56'd0, q[0]});
         else if (zero_ok)
            chk("out_data_rst", {56'd0, out_data}, 64'd0);
`ifdef SERIALIZER_LAST_EN
         chk("out_last", {63'd0, out_last}, {63'd0, (q.size() == 1)});
`endif
      end
      ihs = iv & exp_ready;
      ohs = exp_valid & ordy;
      if (!r) begin
         q.delete();
         zero_ok = 1'b1;
      end else begin
         if (ohs) void'(q.pop_front());
         if (ihs) begin
            for (int k = 0; k < RATIO; k++) q.push_back(id[k*OW +: OW]);
            zero_ok = 1'b0;
            n_acc++;
         end
      end
   endtask

   localparam logic [IW-1:0] W1 = 64'h0807060504030201;
   localparam logic [IW-1:0] W2 = 64'h100F0E0D0C0B0A09;
   localparam logic [IW-1:0] WA = 64'hAAAAAAAAAAAAAAAA;

   initial begin
      rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      step(1'b0, 1'b1, W1, 1'b1);
      armed = 1'b1;
      step(1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0);

      // Single word with the consumer always ready.
      step(1'b1, 1'b1, W1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b1);

      // Two words back to back.
      n_acc = 0;
      for (int i = 0; i < 20; i++)
         step(1'b1, n_acc < 2, (n_acc == 0) ? W1 : W2, 1'b1);

      // Backpressure while slice 0x04 is shown.
      step(1'b1, 1'b1, W1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0, 1'b1);

      // Reset after three slices, then a fresh word.
      step(1'b1, 1'b1, W1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
      step(1'b0, 1'b1, W2, 1'b1);
      step(1'b1, 1'b0, W2, 1'b1);
      step(1'b1, 1'b1, WA, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b1);

      // Random traffic with occasional resets.
      for (int i = 0; i < 2000; i++)
         step(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 3) != 0),
              {$urandom, $urandom},
              ($urandom_range(0, 3) != 0));

      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, 1'b1);
      chk("drained", {63'd0, out_valid}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
